rect_fill_engine: RTL and testbench

RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

---
 rtl/rect_fill_engine.sv | 165 ++++++++++++++++
 tb/tb_rect_fill_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: a memory-mapped block that paints a clipped,
// solid-colour rectangle into VRAM, one pixel per clock in raster order.
module rect_fill_engine #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] status_o,
    output logic        v_we_o,
    output logic [14:0] v_addr_o,
    output logic [7:0]  v_data_o,
    output logic        done_intr_o
);

    localparam logic [31:0] ADDR_XY  = 32'h1100_C014;
    localparam logic [31:0] ADDR_WH  = 32'h1100_C018;
    localparam logic [31:0] ADDR_COL = 32'h1100_C01C;
    localparam logic [31:0] ADDR_CTL = 32'h1100_C020;

    localparam logic [9:0]  HR10 = 10'(H_RES);
    localparam logic [9:0]  VR10 = 10'(V_RES);
    localparam logic [14:0] HR15 = 15'(H_RES);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t state, state_n;

    // Programmed configuration
    logic [7:0]  x0_r, y0_r, color_r;
    logic [8:0]  w_r, h_r;

    // Active-fill bookkeeping
    logic [9:0]  xe_l, ye_l, x_c, y_c;
    logic [14:0] row_base;
    logic        busy_r, done_r;

    logic        wr_ctl, start_req, clr_req, cfg_ok;
    logic [9:0]  x_sum, y_sum, xe_c, ye_c;
    logic        empty, last_px;
    logic [15:0] y0_base;
    logic [14:0] next_row;

    // Y0*H_RES by summing shifted copies of Y0 for each set bit of H_RES
    function automatic logic [15:0] mul_hres(input logic [7:0] y);
        logic [15:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 15; i++) begin
            if (HR15[i]) acc = acc + ({8'b0, y} << i);
        end
        return acc;
    endfunction

    assign wr_ctl    = iobus_wr && (iobus_addr == ADDR_CTL);
    assign start_req = wr_ctl && iobus_out[0];
    assign clr_req   = wr_ctl && iobus_out[1];
    assign cfg_ok    = iobus_wr && (state == S_IDLE);

    // 10-bit sums so X0+W / Y0+H never wrap before clipping
    assign x_sum = {2'b0, x0_r} + {1'b0, w_r};
    assign y_sum = {2'b0, y0_r} + {1'b0, h_r};
    assign xe_c  = (x_sum > HR10) ? HR10 - 10'd1 : x_sum - 10'd1;
    assign ye_c  = (y_sum > VR10) ? VR10 - 10'd1 : y_sum - 10'd1;
    assign empty = (w_r == '0) || (h_r == '0) ||
                   ({2'b0, x0_r} >= HR10) || ({2'b0, y0_r} >= VR10);

    assign last_px  = (x_c == xe_l) && (y_c == ye_l);
    assign y0_base  = mul_hres(y0_r);
    assign next_row = row_base + HR15;

    assign status_o = {30'b0, done_r, busy_r};

    logic unused_bits;
    assign unused_bits = ^{iobus_out[31:25], iobus_out[15:9], y0_base[15]};

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state: accept START only from IDLE; leave FILL after the last pixel
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_req) state_n = empty ? S_DONE : S_FILL;
            S_FILL:  if (last_px) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Config registers, pixel walker and registered outputs
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            x0_r        <= '0;
            y0_r        <= '0;
            w_r         <= '0;
            h_r         <= '0;
            color_r     <= '0;
            xe_l        <= '0;
            ye_l        <= '0;
            x_c         <= '0;
            y_c         <= '0;
            row_base    <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            v_we_o      <= 1'b0;
            v_addr_o    <= '0;
            v_data_o    <= '0;
            done_intr_o <= 1'b0;
        end else begin
            if (cfg_ok && iobus_addr == ADDR_XY) begin
                x0_r <= iobus_out[7:0];
                y0_r <= iobus_out[23:16];
            end
            if (cfg_ok && iobus_addr == ADDR_WH) begin
                w_r <= iobus_out[8:0];
                h_r <= iobus_out[24:16];
            end
            if (cfg_ok && iobus_addr == ADDR_COL) color_r <= iobus_out[7:0];

            busy_r      <= (state_n != S_IDLE);
            v_we_o      <= (state_n == S_FILL);
            done_intr_o <= (state_n == S_DONE);

            // Entering DONE sets the flag; a clear landing in DONE loses to it
            if (state_n == S_DONE)                done_r <= 1'b1;
            else if (clr_req && state != S_DONE)  done_r <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start_req && !empty) begin
                        xe_l     <= xe_c;
                        ye_l     <= ye_c;
                        x_c      <= {2'b0, x0_r};
                        y_c      <= {2'b0, y0_r};
                        row_base <= y0_base[14:0];
                        v_addr_o <= y0_base[14:0] + {7'b0, x0_r};
                        v_data_o <= color_r;
                    end
                end
                S_FILL: begin
                    // Within a row the address steps by one; a new row restarts from row base + X0
                    if (!last_px) begin
                        if (x_c == xe_l) begin
                            x_c      <= {2'b0, x0_r};
                            y_c      <= y_c + 10'd1;
                            row_base <= next_row;
                            v_addr_o <= next_row + {7'b0, x0_r};
                        end else begin
                            x_c      <= x_c + 10'd1;
                            v_addr_o <= v_addr_o + 15'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed cases plus randomized
// fills checked against a pixel-list reference model.
module tb_rect_fill_engine;

    localparam int H_RES = 160;
    localparam int V_RES = 120;

    localparam logic [31:0] ADDR_XY  = 32'h1100_C014;
    localparam logic [31:0] ADDR_WH  = 32'h1100_C018;
    localparam logic [31:0] ADDR_COL = 32'h1100_C01C;
    localparam logic [31:0] ADDR_CTL = 32'h1100_C020;

    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] iobus_addr = '0;
    logic [31:0] iobus_out = '0;
    logic        iobus_wr = 1'b0;
    logic [31:0] status_o;
    logic        v_we_o;
    logic [14:0] v_addr_o;
    logic [7:0]  v_data_o;
    logic        done_intr_o;

    rect_fill_engine #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk         (clk),
        .RST         (RST),
        .iobus_addr  (iobus_addr),
        .iobus_out   (iobus_out),
        .iobus_wr    (iobus_wr),
        .status_o    (status_o),
        .v_we_o      (v_we_o),
        .v_addr_o    (v_addr_o),
        .v_data_o    (v_data_o),
        .done_intr_o (done_intr_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the programmed configuration and sticky flag
    int          mx0 = 0, my0 = 0, mw = 0, mh = 0;
    logic [7:0]  mcol = '0;
    logic        m_done = 1'b0;

    // Bus writes injected at given cycle offsets while a fill runs
    int          inj_n = 0;
    int          inj_at[4];
    logic [31:0] inj_a[4];
    logic [31:0] inj_d[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        iobus_addr = a;
        iobus_out  = d;
        iobus_wr   = 1'b1;
        @(negedge clk);
        iobus_wr   = 1'b0;
    endtask

    // Program the fields selected by mask (1=XY, 2=WH, 4=COLOR), START with
    // control word sw, then check every cycle through DONE and back to IDLE.
    task automatic run_fill(input int mask, input int x0, input int y0, input int w,
                            input int h, input logic [7:0] col, input logic [1:0] sw);
        int          exp_q[$];
        int          n;
        logic [31:0] st_fill;
        if ((mask & 1) != 0) begin
            mx0 = x0; my0 = y0;
            io_write(ADDR_XY, {8'h0, 8'(y0), 8'h0, 8'(x0)});
        end
        if ((mask & 2) != 0) begin
            mw = w; mh = h;
            io_write(ADDR_WH, {7'h0, 9'(h), 7'h0, 9'(w)});
        end
        if ((mask & 4) != 0) begin
            mcol = col;
            io_write(ADDR_COL, {24'h0, col});
        end
        for (int y = my0; y < my0 + mh; y++)
            if (y < V_RES)
                for (int x = mx0; x < mx0 + mw; x++)
                    if (x < H_RES) exp_q.push_back(y * H_RES + x);
        n = exp_q.size();
        if (sw[1]) m_done = 1'b0;
        st_fill = {30'h0, m_done, 1'b1};

        @(negedge clk);
        iobus_addr = ADDR_CTL;
        iobus_out  = {30'h0, sw};
        iobus_wr   = 1'b1;
        @(negedge clk);
        for (int c = 0; c < n + 2; c++) begin
            iobus_wr = 1'b0;
            for (int j = 0; j < inj_n; j++) begin
                if (inj_at[j] == c) begin
                    iobus_addr = inj_a[j];
                    iobus_out  = inj_d[j];
                    iobus_wr   = 1'b1;
                end
            end
            if (c < n) begin
                check("fill_we", {31'h0, v_we_o}, 32'h1);
                check("fill_addr", {17'h0, v_addr_o}, exp_q[c]);
                check("fill_data", {24'h0, v_data_o}, {24'h0, mcol});
                check("fill_status", status_o, st_fill);
                check("fill_intr", {31'h0, done_intr_o}, 32'h0);
            end else if (c == n) begin
                check("done_we", {31'h0, v_we_o}, 32'h0);
                check("done_intr", {31'h0, done_intr_o}, 32'h1);
                check("done_status", status_o, 32'h3);
            end else begin
                check("idle_we", {31'h0, v_we_o}, 32'h0);
                check("idle_intr", {31'h0, done_intr_o}, 32'h0);
                check("idle_status", status_o, 32'h2);
            end
            @(negedge clk);
        end
        iobus_wr = 1'b0;
        m_done   = 1'b1;
        inj_n    = 0;
    endtask

    initial begin
        #1 RST = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_we", {31'h0, v_we_o}, 32'h0);
        check("rst_addr", {17'h0, v_addr_o}, 32'h0);
        check("rst_data", {24'h0, v_data_o}, 32'h0);
        check("rst_intr", {31'h0, done_intr_o}, 32'h0);
        check("rst_status", status_o, 32'h0);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_status", status_o, 32'h0);
        check("post_rst_we", {31'h0, v_we_o}, 32'h0);

        // Basic 3x2 fill
        run_fill(7, 2, 3, 3, 2, 8'hE0, 2'b01);
        // Clipped at bottom-right corner
        run_fill(7, 158, 119, 10, 10, 8'h1C, 2'b01);
        // Zero width: straight to DONE
        run_fill(2, 0, 0, 0, 2, 8'h00, 2'b01);

        // START and COLOR write mid-fill are both ignored
        inj_n = 2;
        inj_at[0] = 5; inj_a[0] = ADDR_CTL; inj_d[0] = 32'h1;
        inj_at[1] = 7; inj_a[1] = ADDR_COL; inj_d[1] = 32'hCC;
        run_fill(7, 40, 50, 4, 4, 8'h33, 2'b01);
        // Re-START with no config writes: colour must still be the original
        run_fill(0, 0, 0, 0, 0, 8'h00, 2'b01);

        // Wide W: X0+W exceeds 8 bits and must clip, not wrap
        run_fill(7, 100, 10, 300, 1, 8'h77, 2'b01);

        // Clear sticky done from IDLE
        io_write(ADDR_CTL, 32'h2);
        check("clr_idle_status", status_o, 32'h0);
        m_done = 1'b0;

        // START with clear while done is set
        run_fill(7, 1, 1, 2, 2, 8'h11, 2'b01);
        run_fill(7, 5, 5, 2, 1, 8'h22, 2'b11);

        // START+clear landing in the DONE cycle: both ignored
        inj_n = 1;
        inj_at[0] = 3; inj_a[0] = ADDR_CTL; inj_d[0] = 32'h3;
        run_fill(7, 0, 0, 3, 1, 8'h99, 2'b01);
        repeat (2) begin
            check("after_done_we", {31'h0, v_we_o}, 32'h0);
            check("after_done_status", status_o, 32'h2);
            @(negedge clk);
        end

        // Randomized fills, concentrated near the clipping edges
        for (int i = 0; i < 24; i++) begin
            int         x0, y0, w, h, mask;
            logic [1:0] sw;
            logic [7:0] col;
            x0   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(H_RES - 6, H_RES + 3))
                                               : int'($urandom_range(0, H_RES - 1));
            y0   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(V_RES - 4, V_RES + 2))
                                               : int'($urandom_range(0, V_RES - 1));
            w    = $urandom_range(0, 10);
            h    = $urandom_range(0, 5);
            mask = ($urandom_range(0, 3) == 0) ? 3 : 7;
            sw   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b01;
            col  = 8'($urandom);
            if (w > 0 && h > 0 && x0 < H_RES && y0 < V_RES && $urandom_range(0, 1) == 1) begin
                inj_n = 2;
                inj_at[0] = 0; inj_a[0] = ADDR_CTL; inj_d[0] = 32'h1;
                inj_at[1] = 1; inj_a[1] = ADDR_COL; inj_d[1] = {24'h0, ~col};
            end
            run_fill(mask, x0, y0, w, h, col, sw);
        end

        // Reset in the middle of an 8x8 fill
        io_write(ADDR_XY, {8'h0, 8'd20, 8'h0, 8'd10});
        io_write(ADDR_WH, {7'h0, 9'd8, 7'h0, 9'd8});
        io_write(ADDR_COL, 32'h5A);
        @(negedge clk);
        iobus_addr = ADDR_CTL;
        iobus_out  = 32'h1;
        iobus_wr   = 1'b1;
        @(negedge clk);
        iobus_wr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("pre_rst_we", {31'h0, v_we_o}, 32'h1);
            check("pre_rst_addr", {17'h0, v_addr_o}, 20 * H_RES + 10 + c);
            if (c < 4) @(negedge clk);
        end
        #2 RST = 1'b1;
        #1;
        check("async_rst_we", {31'h0, v_we_o}, 32'h0);
        check("async_rst_addr", {17'h0, v_addr_o}, 32'h0);
        check("async_rst_data", {24'h0, v_data_o}, 32'h0);
        check("async_rst_intr", {31'h0, done_intr_o}, 32'h0);
        check("async_rst_status", status_o, 32'h0);
        @(negedge clk);
        RST = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check("abort_we", {31'h0, v_we_o}, 32'h0);
            check("abort_intr", {31'h0, done_intr_o}, 32'h0);
            check("abort_status", status_o, 32'h0);
        end
        mx0 = 0; my0 = 0; mw = 0; mh = 0; mcol = 8'h00; m_done = 1'b0;
        run_fill(2, 0, 0, 1, 1, 8'h00, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
